// File: rtl/disp_convert_arbiter.sv
// Round-robin sharing of one float2fixed_3x displacement converter among NUM_REQ requesters,
// with a latency-matched tag pipeline and an in-order, credit-protected response FIFO.
module disp_convert_arbiter #(
    parameter int NUM_REQ             = 4,
    parameter int CONV_LATENCY        = 2,
    parameter int ID_WIDTH            = 8,
    parameter int FIFO_DEPTH          = 8,
    parameter int FLOAT_STRUCT_WIDTH  = 96,
    parameter int OFFSET_STRUCT_WIDTH = 48,
    localparam int SRC_W              = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*FLOAT_STRUCT_WIDTH-1:0]  req_disp,
    input  logic [NUM_REQ*OFFSET_STRUCT_WIDTH-1:0] req_offset,
    input  logic [NUM_REQ*ID_WIDTH-1:0]        req_id,
    output logic [FLOAT_STRUCT_WIDTH-1:0]      conv_disp,
    output logic [OFFSET_STRUCT_WIDTH-1:0]     conv_offset,
    input  logic [1:0]                         conv_cell_x,
    input  logic [1:0]                         conv_cell_y,
    input  logic [1:0]                         conv_cell_z,
    input  logic [OFFSET_STRUCT_WIDTH-1:0]     conv_result,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [SRC_W-1:0]                   rsp_src,
    output logic [ID_WIDTH-1:0]                rsp_id,
    output logic [OFFSET_STRUCT_WIDTH-1:0]     rsp_offset,
    output logic [5:0]                         rsp_cell,
    output logic                               rsp_migrate,
    output logic                               busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [SRC_W-1:0]               r_rr_ptr;
    logic [FLOAT_STRUCT_WIDTH-1:0]  r_conv_disp;
    logic [OFFSET_STRUCT_WIDTH-1:0] r_conv_offset;
    logic [CONV_LATENCY:0]          r_vld_p;
    logic [SRC_W-1:0]               r_src_p [CONV_LATENCY+1];
    logic [ID_WIDTH-1:0]            r_id_p  [CONV_LATENCY+1];
    logic [CNT_W-1:0]               r_inflight;
    logic [CNT_W-1:0]               r_count;
    logic [PTR_W-1:0]               r_wr_ptr;
    logic [PTR_W-1:0]               r_rd_ptr;

    logic [SRC_W-1:0]               r_mem_src    [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]            r_mem_id     [FIFO_DEPTH];
    logic [OFFSET_STRUCT_WIDTH-1:0] r_mem_offset [FIFO_DEPTH];
    logic [5:0]                     r_mem_cell   [FIFO_DEPTH];

    logic             w_grant_vld;
    logic [SRC_W-1:0] w_grant_idx;
    logic [SRC_W:0]   w_scan_idx;
    logic [SRC_W-1:0] w_next_ptr;
    logic             w_can_issue;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit covers every request that will eventually occupy a FIFO slot.
    assign w_can_issue = ((CNT_W+1)'(r_inflight) + (CNT_W+1)'(r_count)) < (CNT_W+1)'(FIFO_DEPTH);

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan_idx = {1'b0, r_rr_ptr} + (SRC_W+1)'(i);
            if (w_scan_idx >= (SRC_W+1)'(NUM_REQ)) begin
                w_scan_idx = w_scan_idx - (SRC_W+1)'(NUM_REQ);
            end
            if (!w_grant_vld && req_valid[w_scan_idx[SRC_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_scan_idx[SRC_W-1:0];
            end
        end
    end

    assign w_next_ptr = (w_grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
    assign w_issue    = !rst && w_can_issue && w_grant_vld;

    always_comb begin
        req_ready = '0;
        if (w_issue) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_push = r_vld_p[CONV_LATENCY];
    assign w_pop  = rsp_valid && rsp_ready;

    // Stage p0: converter input register; p1..pN: tag alignment with converter latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_conv_disp   <= '0;
            r_conv_offset <= '0;
            r_vld_p       <= '0;
            r_inflight    <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            if (w_issue) begin
                r_rr_ptr      <= w_next_ptr;
                r_conv_disp   <= req_disp[w_grant_idx*FLOAT_STRUCT_WIDTH +: FLOAT_STRUCT_WIDTH];
                r_conv_offset <= req_offset[w_grant_idx*OFFSET_STRUCT_WIDTH +: OFFSET_STRUCT_WIDTH];
            end
            r_vld_p    <= {r_vld_p[CONV_LATENCY-1:0], w_issue};
            r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_push);
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        r_src_p[0] <= w_grant_idx;
        r_id_p[0]  <= req_id[w_grant_idx*ID_WIDTH +: ID_WIDTH];
        for (int k = 1; k <= CONV_LATENCY; k++) begin
            r_src_p[k] <= r_src_p[k-1];
            r_id_p[k]  <= r_id_p[k-1];
        end
        if (w_push) begin
            r_mem_src[r_wr_ptr]    <= r_src_p[CONV_LATENCY];
            r_mem_id[r_wr_ptr]     <= r_id_p[CONV_LATENCY];
            r_mem_offset[r_wr_ptr] <= conv_result;
            r_mem_cell[r_wr_ptr]   <= {conv_cell_z, conv_cell_y, conv_cell_x};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_push && r_count == CNT_W'(FIFO_DEPTH)));
        end
    end

    assign conv_disp   = r_conv_disp;
    assign conv_offset = r_conv_offset;
    assign rsp_valid   = (r_count != '0);
    assign rsp_src     = r_mem_src[r_rd_ptr];
    assign rsp_id      = r_mem_id[r_rd_ptr];
    assign rsp_offset  = r_mem_offset[r_rd_ptr];
    assign rsp_cell    = r_mem_cell[r_rd_ptr];
    // 2'b01 encodes "same cell"; anything else means the particle crossed a boundary.
    assign rsp_migrate = (rsp_cell[1:0] != 2'b01) || (rsp_cell[3:2] != 2'b01) || (rsp_cell[5:4] != 2'b01);
    assign busy        = (r_inflight != '0) || (r_count != '0);

endmodule

// File: tb/tb_disp_convert_arbiter.sv
// Directed bench for disp_convert_arbiter with a two-cycle behavioural converter model.
module tb_disp_convert_arbiter;

    localparam int NR  = 4;
    localparam int IDW = 8;
    localparam int FW  = 96;
    localparam int OW  = 48;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*FW-1:0]  req_disp;
    logic [NR*OW-1:0]  req_offset;
    logic [NR*IDW-1:0] req_id;
    logic [FW-1:0]     conv_disp;
    logic [OW-1:0]     conv_offset;
    logic [1:0]        conv_cell_x, conv_cell_y, conv_cell_z;
    logic [OW-1:0]     conv_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_src;
    logic [IDW-1:0]    rsp_id;
    logic [OW-1:0]     rsp_offset;
    logic [5:0]        rsp_cell;
    logic              rsp_migrate;
    logic              busy;

    disp_convert_arbiter #(
        .NUM_REQ(NR), .CONV_LATENCY(2), .ID_WIDTH(IDW), .FIFO_DEPTH(8),
        .FLOAT_STRUCT_WIDTH(FW), .OFFSET_STRUCT_WIDTH(OW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_disp(req_disp), .req_offset(req_offset), .req_id(req_id),
        .conv_disp(conv_disp), .conv_offset(conv_offset),
        .conv_cell_x(conv_cell_x), .conv_cell_y(conv_cell_y), .conv_cell_z(conv_cell_z),
        .conv_result(conv_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_src(rsp_src), .rsp_id(rsp_id), .rsp_offset(rsp_offset),
        .rsp_cell(rsp_cell), .rsp_migrate(rsp_migrate), .busy(busy)
    );

    always #5 clk = ~clk;

    // Converter model: per axis, cell 00 if negative, 10 if |v|>=2, else 01;
    // new offset = old offset + top 16 mantissa bits.
    function automatic logic [53:0] conv_fn(input logic [95:0] d, input logic [47:0] o);
        logic [5:0]  c;
        logic [47:0] r;
        logic [31:0] f;
        for (int a = 0; a < 3; a++) begin
            f = d[32*a +: 32];
            c[2*a +: 2]  = f[31] ? 2'b00 : ((f[30:23] >= 8'd128) ? 2'b10 : 2'b01);
            r[16*a +: 16] = o[16*a +: 16] + f[22:7];
        end
        return {c, r};
    endfunction

    logic [53:0] c1 = '0;
    logic [53:0] c2 = '0;
    always @(posedge clk) begin
        c1 <= conv_fn(conv_disp, conv_offset);
        c2 <= c1;
    end
    assign conv_result = c2[47:0];
    assign {conv_cell_z, conv_cell_y, conv_cell_x} = c2[53:48];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [95:0] d, input logic [47:0] o, input logic [7:0] id);
        req_disp[i*FW +: FW]    = d;
        req_offset[i*OW +: OW]  = o;
        req_id[i*IDW +: IDW]    = id;
    endtask

    logic [3:0] held;
    int         wait_cnt [NR];
    int         max_wait;
    int         q [$];
    int         g;
    int         n_seen;
    int         exp_src;

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        rsp_ready  = 1'b0;
        req_disp   = '0;
        req_offset = '0;
        req_id     = '0;

        // Reset state
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_conv_disp", conv_disp, 0);
        chk("rst_conv_offset", conv_offset, 0);
        chk("rst_busy", busy, 0);

        // Single request: x = 1.5f from requester 0, id 7
        cyc();
        set_req(0, {64'h0, 32'h3FC00000}, 48'h0, 8'd7);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        chk("single_ready", req_ready, 4'b0001);
        cyc();
        req_valid = 4'b0000;
        #1;
        chk("single_conv_disp", conv_disp, {64'h0, 32'h3FC00000});
        chk("single_busy", busy, 1);
        cyc();
        cyc();
        #1;
        chk("single_early", rsp_valid, 0);
        cyc();
        #1;
        chk("single_valid", rsp_valid, 1);
        chk("single_src", rsp_src, 0);
        chk("single_id", rsp_id, 7);
        chk("single_offset", rsp_offset, 48'h0000_0000_8000);
        chk("single_cell", rsp_cell, 6'b010101);
        chk("single_migrate", rsp_migrate, 0);
        cyc();
        #1;
        chk("single_gone", rsp_valid, 0);
        chk("single_idle", busy, 0);

        // Migration: requester 3, id 3, x = 2.5f -> cell_x = 10
        cyc();
        set_req(3, {64'h0, 32'h40200000}, 48'h0000_0000_0010, 8'd3);
        req_valid = 4'b1000;
        #1;
        chk("mig_ready", req_ready, 4'b1000);
        cyc();
        req_valid = 4'b0000;
        cyc();
        cyc();
        cyc();
        #1;
        chk("mig_valid", rsp_valid, 1);
        chk("mig_src", rsp_src, 3);
        chk("mig_id", rsp_id, 3);
        chk("mig_offset", rsp_offset, 48'h0000_0000_4010);
        chk("mig_cell", rsp_cell, 6'b010110);
        chk("mig_migrate", rsp_migrate, 1);
        cyc();
        #1;
        chk("mig_gone", rsp_valid, 0);

        // All four requesters continuously valid, consumer always ready
        for (int i = 0; i < NR; i++) begin
            set_req(i, {64'h0, 32'h3F800000}, 48'(256 + i), 8'(16 + i));
        end
        for (int k = 0; k < 13; k++) begin
            cyc();
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            if (k < 8) chk("rr_grant", req_ready, 4'b0001 << (k % 4));
            if (k >= 4 && k < 12) begin
                chk("rr_rsp_valid", rsp_valid, 1);
                chk("rr_rsp_src", rsp_src, (k - 4) % 4);
                chk("rr_rsp_id", rsp_id, 16 + (k - 4) % 4);
                chk("rr_rsp_offset", rsp_offset, 256 + (k - 4) % 4);
            end
            if (k == 12) chk("rr_drained", rsp_valid, 0);
        end

        // Backpressure: credit allows exactly FIFO_DEPTH issues
        rsp_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            req_valid = 4'hF;
            #1;
            chk("bp_grant", req_ready, (k < 8) ? (1 << (k % 4)) : 0);
            if (k >= 8) begin
                chk("bp_hold_valid", rsp_valid, 1);
                chk("bp_hold_src", rsp_src, 0);
                chk("bp_hold_id", rsp_id, 16);
            end
        end
        for (int k = 0; k < 8; k++) begin
            cyc();
            req_valid = 4'h0;
            rsp_ready = 1'b1;
            #1;
            chk("bp_drain_valid", rsp_valid, 1);
            chk("bp_drain_src", rsp_src, k % 4);
            chk("bp_drain_id", rsp_id, 16 + k % 4);
        end
        cyc();
        #1;
        chk("bp_empty", rsp_valid, 0);
        chk("bp_idle", busy, 0);
        cyc();
        req_valid = 4'hF;
        #1;
        chk("bp_resume", req_ready, 4'b0001);
        cyc();
        req_valid = 4'h0;
        repeat (6) cyc();

        // Reset with 3 in flight and 2 queued
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            req_valid = 4'hF;
            #1;
            chk("mid_issue", req_ready != 0, 1);
        end
        cyc();
        req_valid = 4'h0;
        rst = 1'b1;
        #1;
        chk("mid_pre_valid", rsp_valid, 1);
        chk("mid_pre_busy", busy, 1);
        cyc();
        rst = 1'b0;
        #1;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_busy", busy, 0);
        req_valid = 4'hF;
        #1;
        chk("mid_rr_ptr", req_ready, 4'b0001);
        rsp_ready = 1'b1;
        n_seen = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            req_valid = 4'h0;
            #1;
            if (rsp_valid) begin
                n_seen++;
                chk("mid_post_src", rsp_src, 0);
            end
        end
        chk("mid_no_stale", n_seen, 1);
        chk("mid_idle", busy, 0);

        // Requester 2 alone, then requester 1 joins with rr_ptr at 3
        cyc();
        req_valid = 4'b0100;
        #1;
        chk("fair_r2", req_ready, 4'b0100);
        cyc();
        req_valid = 4'b0110;
        #1;
        chk("fair_r1_first", req_ready, 4'b0010);
        cyc();
        #1;
        chk("fair_r2_next", req_ready, 4'b0100);
        cyc();
        #1;
        chk("fair_r1_again", req_ready, 4'b0010);
        cyc();
        req_valid = 4'b0000;
        repeat (6) cyc();

        // Random traffic with held requests and random backpressure
        held     = '0;
        max_wait = 0;
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 100; c++) begin
            cyc();
            req_valid = held | 4'($urandom_range(0, 15));
            rsp_ready = 1'($urandom_range(0, 1));
            #1;
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && !held[i]) wait_cnt[i] = 0;
            end
            chk("rnd_onehot", $onehot0(req_ready), 1);
            chk("rnd_subset", req_ready & ~req_valid, 0);
            if (rsp_valid && rsp_ready) begin
                exp_src = (q.size() > 0) ? q.pop_front() : 99;
                chk("rnd_rsp_src", rsp_src, exp_src);
            end
            g = -1;
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i]) g = i;
            end
            if (g >= 0) begin
                q.push_back(g);
                for (int i = 0; i < NR; i++) begin
                    if (i != g && req_valid[i]) begin
                        wait_cnt[i]++;
                        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                    end
                end
                wait_cnt[g] = 0;
            end
            held = req_valid & ~req_ready;
        end
        chk("rnd_no_starve", max_wait <= NR - 1, 1);
        for (int c = 0; c < 20; c++) begin
            cyc();
            req_valid = 4'h0;
            rsp_ready = 1'b1;
            #1;
            if (rsp_valid) begin
                exp_src = (q.size() > 0) ? q.pop_front() : 99;
                chk("rnd_drain_src", rsp_src, exp_src);
            end
        end
        chk("rnd_queue_empty", q.size(), 0);
        chk("rnd_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
